// File: rtl/db9md_pad_scanner.sv
// db9md_pad_scanner: scans two Mega Drive 3/6-button pads through one DB9 port
// with a split multiplexer, producing active-high 16-bit joystick words.
// Optional: define DB9MD_DEBOUNCE_EN to commit a pad's word only after two
// identical consecutive scans.
module db9md_pad_scanner #(
    parameter int unsigned HALF_CYCLES = 250,
    parameter int unsigned IDLE_CYCLES = 100000
) (
    input  logic        clk_50,
    input  logic        RESET_L,
    input  logic [5:0]  joy_in,
    output logic        joy_mdsel,
    output logic        joy_split,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        pad6_1,
    output logic        pad6_2
);

    localparam int unsigned HW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
    localparam int unsigned IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_P0, S_P1, S_P2, S_P3, S_P4, S_P5, S_P6, S_P7,
        S_COMMIT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [HW-1:0]   half_cnt;
    logic            half_sel;
    logic [IW-1:0]   idle_cnt;
    logic            in_phase;
    logic            half_end;
    logic            phase_end;
    logic            sample_en;

    logic [5:0]      joy_meta;
    logic [5:0]      joy_sync;
    logic [5:0]      act;

    // Per-pad shadow captures, index 0 = pad 1, index 1 = pad 2
    logic [5:0]      sh_base    [2];   // C B U D L R
    logic [1:0]      sh_ast     [2];   // Start A
    logic [3:0]      sh_ext     [2];   // Mode X Y Z
    logic            sh_present [2];
    logic            sh_six     [2];
    logic [11:0]     new_word   [2];
    logic            new_six    [2];

    assign half_end  = (half_cnt == HALF_LAST);
    assign phase_end = half_end & half_sel;
    assign sample_en = in_phase & half_end;
    assign act       = ~joy_sync;

    // State register
    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and pad select / split outputs
    always_comb begin
        state_next = state;
        joy_mdsel  = 1'b1;
        joy_split  = 1'b0;
        in_phase   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (idle_cnt == IDLE_LAST) state_next = S_P0;
            end
            S_P0: begin
                in_phase = 1'b1; joy_split = half_sel;
                if (phase_end) state_next = S_P1;
            end
            S_P1: begin
                in_phase = 1'b1; joy_split = half_sel; joy_mdsel = 1'b0;
                if (phase_end) state_next = S_P2;
            end
            S_P2: begin
                in_phase = 1'b1; joy_split = half_sel;
                if (phase_end) state_next = S_P3;
            end
            S_P3: begin
                in_phase = 1'b1; joy_split = half_sel; joy_mdsel = 1'b0;
                if (phase_end) state_next = S_P4;
            end
            S_P4: begin
                in_phase = 1'b1; joy_split = half_sel;
                if (phase_end) state_next = S_P5;
            end
            S_P5: begin
                in_phase = 1'b1; joy_split = half_sel; joy_mdsel = 1'b0;
                if (phase_end) state_next = S_P6;
            end
            S_P6: begin
                in_phase = 1'b1; joy_split = half_sel;
                if (phase_end) state_next = S_P7;
            end
            S_P7: begin
                in_phase = 1'b1; joy_split = half_sel; joy_mdsel = 1'b0;
                if (phase_end) state_next = S_COMMIT;
            end
            S_COMMIT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Idle and half-phase counters; both restart at every boundary
    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            idle_cnt <= '0;
            half_cnt <= '0;
            half_sel <= 1'b0;
        end else begin
            if (state == S_IDLE && idle_cnt != IDLE_LAST) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
            if (in_phase) begin
                if (half_end) begin
                    half_cnt <= '0;
                    half_sel <= ~half_sel;
                end else begin
                    half_cnt <= half_cnt + 1'b1;
                end
            end else begin
                half_cnt <= '0;
                half_sel <= 1'b0;
            end
        end
    end

    // Two-flop synchronizer for the raw pad pins
    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            joy_meta <= '1;
            joy_sync <= '1;
        end else begin
            joy_meta <= joy_in;
            joy_sync <= joy_meta;
        end
    end

    // Capture pad fields at the last clock of each half; half_sel picks the pad
    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            for (int unsigned p = 0; p < 2; p++) begin
                sh_base[p]    <= '0;
                sh_ast[p]     <= '0;
                sh_ext[p]     <= '0;
                sh_present[p] <= 1'b0;
                sh_six[p]     <= 1'b0;
            end
        end else if (sample_en) begin
            unique case (state)
                S_P0: sh_base[half_sel] <= {act[5], act[4], act[0], act[1], act[2], act[3]};
                S_P1: begin
                    sh_ast[half_sel]     <= {act[5], act[4]};
                    sh_present[half_sel] <= act[2] & act[3];
                end
                S_P5: sh_six[half_sel] <= &act[3:0];
                S_P6: if (sh_six[half_sel]) sh_ext[half_sel] <= {act[3], act[2], act[1], act[0]};
                default: ;
            endcase
        end
    end

    // Assemble the word each pad would report if committed now
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            new_word[p] = {6'b0, sh_base[p]};
            new_six[p]  = sh_present[p] & sh_six[p];
            if (sh_present[p]) begin
                new_word[p] = {sh_ext[p] & {4{sh_six[p]}}, sh_ast[p], sh_base[p]};
            end
        end
    end

`ifdef DB9MD_DEBOUNCE_EN
    logic [11:0] prev_word [2];
    logic        prev_six  [2];

    // Commit each pad only when this scan matches the previous scan
    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            joystick1 <= '0;
            joystick2 <= '0;
            pad6_1    <= 1'b0;
            pad6_2    <= 1'b0;
            for (int unsigned p = 0; p < 2; p++) begin
                prev_word[p] <= '0;
                prev_six[p]  <= 1'b0;
            end
        end else if (state == S_COMMIT) begin
            if (new_word[0] == prev_word[0] && new_six[0] == prev_six[0]) begin
                joystick1 <= {4'b0, new_word[0]};
                pad6_1    <= new_six[0];
            end
            if (new_word[1] == prev_word[1] && new_six[1] == prev_six[1]) begin
                joystick2 <= {4'b0, new_word[1]};
                pad6_2    <= new_six[1];
            end
            for (int unsigned p = 0; p < 2; p++) begin
                prev_word[p] <= new_word[p];
                prev_six[p]  <= new_six[p];
            end
        end
    end
`else
    // Commit both pads together once per completed scan
    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            joystick1 <= '0;
            joystick2 <= '0;
            pad6_1    <= 1'b0;
            pad6_2    <= 1'b0;
        end else if (state == S_COMMIT) begin
            joystick1 <= {4'b0, new_word[0]};
            joystick2 <= {4'b0, new_word[1]};
            pad6_1    <= new_six[0];
            pad6_2    <= new_six[1];
        end
    end
`endif

endmodule
